uart_rx_frame_ctrl: RTL



---
 rtl/uart_rx_frame_ctrl_pkg.sv | 27 ++
 rtl/uart_rx_timeout.sv | 32 +++
 rtl/uart_rx_frame_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_pkg.sv
// Shared definitions for the UART receive frame controller.
//   state_t   : frame sequencer states
//   ERR_*     : error codes presented on oErr_Code
//   DEF_SOF   : default start-of-frame byte
//   isBusy()  : true while a frame is being collected (timeout window)
package uart_rx_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_HOLD    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_LEN = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  localparam logic [7:0] DEF_SOF = 8'hAA;

  function automatic logic isBusy(input state_t s);
    return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Inter-byte timeout counter.
//   iClk, iRst_n : clock, asynchronous active-low reset
//   iClr         : synchronous clear (has priority over iEn)
//   iEn          : count enable
//   oTc          : terminal count (counter at P_TIMEOUT-1 while enabled)
module uart_rx_timeout #(
  parameter int unsigned P_TIMEOUT = 1_000_000
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iClr,
  input  logic iEn,
  output logic oTc
);

  localparam int unsigned CW = (P_TIMEOUT > 1) ? $clog2(P_TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt <= '0;
    end else if (iClr) begin
      cnt <= '0;
    end else if (iEn) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign oTc = iEn && (cnt == CW'(P_TIMEOUT - 1));

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller.
// Collects SOF, CMD, LEN, LEN payload bytes and an XOR checksum from the
// receiver byte stream and presents validated commands on a valid/ready
// handshake.
//   iClk, iRst_n  : clock, asynchronous active-low reset
//   iRx_Data      : received byte, qualified by iRx_Done
//   iRx_Done      : 1-cycle byte strobe
//   iCmd_Ready    : consumer accepts the held command
//   oCmd_Valid    : command available, held until accepted
//   oCmd          : command byte
//   oCmd_Len      : payload length
//   oPayload      : payload, byte k at [8k+7:8k], unused bytes zero
//   oBusy         : frame collection in progress
//   oErr          : 1-cycle error pulse
//   oErr_Code     : last error code (checksum / length / timeout)
//   oOvr          : 1-cycle pulse when a byte is dropped while holding
module uart_rx_frame_ctrl
  import uart_rx_frame_ctrl_pkg::*;
#(
  parameter logic [7:0]  P_SOF     = DEF_SOF,
  parameter int unsigned P_MAX_LEN = 4,
  parameter int unsigned P_TIMEOUT = 1_000_000
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic [7:0]             iRx_Data,
  input  logic                   iRx_Done,
  input  logic                   iCmd_Ready,
  output logic                   oCmd_Valid,
  output logic [7:0]             oCmd,
  output logic [3:0]             oCmd_Len,
  output logic [8*P_MAX_LEN-1:0] oPayload,
  output logic                   oBusy,
  output logic                   oErr,
  output logic [1:0]             oErr_Code,
  output logic                   oOvr
);

  state_t     state;
  logic [7:0] chk;
  logic [3:0] idx;
  logic       tmoTc;
  logic       tmoEn;
  logic       tmoClr;

  assign tmoEn  = isBusy(state);
  assign tmoClr = iRx_Done || !tmoEn;

  uart_rx_timeout #(
    .P_TIMEOUT(P_TIMEOUT)
  ) uTimeout (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iClr  (tmoClr),
    .iEn   (tmoEn),
    .oTc   (tmoTc)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= ST_IDLE;
      chk        <= '0;
      idx        <= '0;
      oCmd_Valid <= 1'b0;
      oCmd       <= '0;
      oCmd_Len   <= '0;
      oPayload   <= '0;
      oBusy      <= 1'b0;
      oErr       <= 1'b0;
      oErr_Code  <= '0;
      oOvr       <= 1'b0;
    end else begin
      oErr <= 1'b0;
      oOvr <= 1'b0;

      // tmoTc is only asserted in collecting states; a byte in the same
      // cycle takes priority and the counter clears instead.
      if (tmoTc && !iRx_Done) begin
        oErr      <= 1'b1;
        oErr_Code <= ERR_TMO;
        state     <= ST_IDLE;
        oBusy     <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (iRx_Done && (iRx_Data == P_SOF)) begin
              state    <= ST_CMD;
              chk      <= '0;
              oPayload <= '0;
              oBusy    <= 1'b1;
            end
          end

          ST_CMD: begin
            if (iRx_Done) begin
              oCmd  <= iRx_Data;
              chk   <= iRx_Data;
              state <= ST_LEN;
            end
          end

          ST_LEN: begin
            if (iRx_Done) begin
              chk <= chk ^ iRx_Data;
              if (iRx_Data > 8'(P_MAX_LEN)) begin
                oErr      <= 1'b1;
                oErr_Code <= ERR_LEN;
                state     <= ST_IDLE;
                oBusy     <= 1'b0;
              end else begin
                oCmd_Len <= iRx_Data[3:0];
                idx      <= '0;
                state    <= (iRx_Data == 8'd0) ? ST_CHK : ST_PAYLOAD;
              end
            end
          end

          ST_PAYLOAD: begin
            if (iRx_Done) begin
              for (int unsigned k = 0; k < P_MAX_LEN; k++) begin
                if (idx == 4'(k)) begin
                  oPayload[8*k +: 8] <= iRx_Data;
                end
              end
              chk <= chk ^ iRx_Data;
              idx <= idx + 4'd1;
              if ((idx + 4'd1) == oCmd_Len) begin
                state <= ST_CHK;
              end
            end
          end

          ST_CHK: begin
            if (iRx_Done) begin
              oBusy <= 1'b0;
              if (iRx_Data == chk) begin
                state      <= ST_HOLD;
                oCmd_Valid <= 1'b1;
              end else begin
                oErr      <= 1'b1;
                oErr_Code <= ERR_CHK;
                state     <= ST_IDLE;
              end
            end
          end

          ST_HOLD: begin
            if (iCmd_Ready) begin
              // Accepting frees the slot this cycle, so a coincident byte
              // is treated as if it arrived in IDLE.
              oCmd_Valid <= 1'b0;
              if (iRx_Done && (iRx_Data == P_SOF)) begin
                state    <= ST_CMD;
                chk      <= '0;
                oPayload <= '0;
                oBusy    <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end else if (iRx_Done) begin
              oOvr <= 1'b1;
            end
          end

          default: begin
            state <= ST_IDLE;
            oBusy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
